// File: rtl/alu_seq_if.sv
// Request/response bundle for alu_seq: valid/ready operation request in, valid/ready result out.
interface alu_seq_if #(
  parameter int unsigned WIDTH = 32
) ();
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       op;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [3:0]       flags_in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic [3:0]       flags_out;
  logic             illegal;

  modport master (
    output in_valid, op, op_a, op_b, flags_in, out_ready,
    input  in_ready, out_valid, result, flags_out, illegal
  );

  modport slave (
    input  in_valid, op, op_a, op_b, flags_in, out_ready,
    output in_ready, out_valid, result, flags_out, illegal
  );
endinterface

// File: rtl/alu_seq.sv
// Handshaked execute-stage ALU with NZCV flags; single-cycle ops plus an iterative shift-add MUL.
module alu_seq #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned SH_BITS = 8
) (
  input logic       clk,
  input logic       rst,
  alu_seq_if.slave  bus
);

  localparam int unsigned CW = $clog2(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  typedef enum logic [3:0] {
    OP_ADD = 4'h0, OP_SUB = 4'h1, OP_AND = 4'h2, OP_ORR = 4'h3,
    OP_EOR = 4'h4, OP_ADC = 4'h5, OP_SBC = 4'h6, OP_LSL = 4'h7,
    OP_LSR = 4'h8, OP_ASR = 4'h9, OP_ROR = 4'hA, OP_MUL = 4'hB
  } alu_op_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_result;
  logic [3:0]       r_flags_out;
  logic             r_illegal;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0] r_mplier;
  logic [1:0]       r_cv;

  logic             w_in_ready;
  logic             w_out_valid;
  logic             w_accept;
  logic             w_last;
  logic [WIDTH-1:0] w_acc_nxt;
  alu_op_t          w_op;
  logic [WIDTH-1:0] w_a;
  logic [WIDTH-1:0] w_b;
  logic [31:0]      w_amt;
  logic [31:0]      w_rot;
  logic [WIDTH-1:0] w_bop;
  logic             w_cin;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_lsl;
  logic [WIDTH:0]   w_lsr;
  logic [WIDTH:0]   w_asr;
  logic [WIDTH-1:0] w_ror;
  logic [WIDTH-1:0] w_res;
  logic             w_c;
  logic             w_v;
  logic             w_ill;
  logic [3:0]       w_flags;

  assign w_op  = alu_op_t'(bus.op);
  assign w_a   = bus.op_a;
  assign w_b   = bus.op_b;
  assign w_amt = 32'(w_b[SH_BITS-1:0]);
  assign w_rot = w_amt % WIDTH;

  // Shifts run on WIDTH+1 bits so the last bit shifted out lands in the extra bit as carry.
  assign w_lsl = {1'b0, w_a} << w_amt;
  assign w_lsr = {w_a, 1'b0} >> w_amt;
  assign w_asr = $signed({w_a, 1'b0}) >>> w_amt;
  assign w_ror = (w_a >> w_rot) | (w_a << (WIDTH - w_rot));

  always_comb begin
    w_bop = w_b;
    w_cin = 1'b0;
    w_res = '0;
    w_c   = bus.flags_in[1];
    w_v   = bus.flags_in[0];
    w_ill = 1'b0;
    case (w_op)
      OP_SUB: begin w_bop = ~w_b; w_cin = 1'b1; end
      OP_SBC: begin w_bop = ~w_b; w_cin = bus.flags_in[1]; end
      OP_ADC: w_cin = bus.flags_in[1];
      default: ;
    endcase
    w_sum = {1'b0, w_a} + {1'b0, w_bop} + {{WIDTH{1'b0}}, w_cin};
    case (w_op)
      OP_ADD, OP_SUB, OP_ADC, OP_SBC: begin
        w_res = w_sum[WIDTH-1:0];
        w_c   = w_sum[WIDTH];
        w_v   = (w_a[WIDTH-1] == w_bop[WIDTH-1]) && (w_sum[WIDTH-1] != w_a[WIDTH-1]);
      end
      OP_AND: w_res = w_a & w_b;
      OP_ORR: w_res = w_a | w_b;
      OP_EOR: w_res = w_a ^ w_b;
      OP_LSL: begin
        w_res = w_a;
        if (w_amt != 0) begin w_res = w_lsl[WIDTH-1:0]; w_c = w_lsl[WIDTH]; end
      end
      OP_LSR: begin
        w_res = w_a;
        if (w_amt != 0) begin w_res = w_lsr[WIDTH:1]; w_c = w_lsr[0]; end
      end
      OP_ASR: begin
        w_res = w_a;
        if (w_amt != 0) begin w_res = w_asr[WIDTH:1]; w_c = w_asr[0]; end
      end
      OP_ROR: begin
        w_res = w_a;
        if (w_amt != 0) begin w_res = w_ror; w_c = w_ror[WIDTH-1]; end
      end
      OP_MUL: ;
      default: w_ill = 1'b1;
    endcase
    w_flags = w_ill ? bus.flags_in : {w_res[WIDTH-1], (w_res == '0), w_c, w_v};
  end

  assign w_last    = (r_cnt == CW'(WIDTH - 1));
  assign w_acc_nxt = r_mplier[0] ? (r_acc + r_mcand) : r_acc;

  always_comb begin
    w_state_nxt = r_state;
    w_in_ready  = 1'b0;
    w_out_valid = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_in_ready = 1'b1;
        if (bus.in_valid) w_state_nxt = (w_op == OP_MUL) ? S_BUSY : S_DONE;
      end
      S_BUSY: if (w_last) w_state_nxt = S_DONE;
      S_DONE: begin
        w_out_valid = 1'b1;
        if (bus.out_ready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_accept = bus.in_valid && w_in_ready;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_result    <= '0;
      r_flags_out <= '0;
      r_illegal   <= 1'b0;
      r_cnt       <= '0;
      r_acc       <= '0;
      r_mcand     <= '0;
      r_mplier    <= '0;
      r_cv        <= '0;
    end else if (w_accept) begin
      if (w_op == OP_MUL) begin
        r_acc    <= '0;
        r_mcand  <= w_a;
        r_mplier <= w_b;
        r_cv     <= bus.flags_in[1:0];
        r_cnt    <= '0;
      end else begin
        r_result    <= w_res;
        r_flags_out <= w_flags;
        r_illegal   <= w_ill;
      end
    end else if (r_state == S_BUSY) begin
      // One multiplier bit per cycle; the final step writes the output registers directly.
      r_acc    <= w_acc_nxt;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_cnt    <= r_cnt + 1'b1;
      if (w_last) begin
        r_result    <= w_acc_nxt;
        r_flags_out <= {w_acc_nxt[WIDTH-1], (w_acc_nxt == '0), r_cv};
        r_illegal   <= 1'b0;
      end
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.result    = r_result;
  assign bus.flags_out = r_flags_out;
  assign bus.illegal   = r_illegal;

endmodule

// File: tb/tb_alu_seq.sv
// Randomised and directed bench for alu_seq against an arithmetic reference model with a per-cycle scoreboard.
module tb_alu_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  alu_seq_if #(.WIDTH(32)) bus ();

  alu_seq #(.WIDTH(32), .SH_BITS(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [31:0] r;
    logic [3:0]  f;
    logic        ill;
    int          due;
  } exp_t;

  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;
  int   ncyc     = 0;
  int   mode     = 2;
  logic chk_en   = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic ovf(input longint s);
    return (s > 64'sd2147483647) || (s < -64'sd2147483648);
  endfunction

  function automatic exp_t model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                 input logic [3:0] fi);
    exp_t        e;
    logic        c, v;
    logic [63:0] u;
    longint      sa, sb, ci, bor;
    int unsigned amt, k;
    c = fi[1]; v = fi[0];
    e.ill = 1'b0; e.r = '0; e.due = 0;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ci  = fi[1] ? 64'sd1 : 64'sd0;
    bor = fi[1] ? 64'sd0 : 64'sd1;
    amt = int'(b[7:0]);
    case (op)
      4'h0: begin u = {32'b0, a} + {32'b0, b}; e.r = u[31:0]; c = u[32]; v = ovf(sa + sb); end
      4'h1: begin e.r = a - b; c = (a >= b); v = ovf(sa - sb); end
      4'h2: e.r = a & b;
      4'h3: e.r = a | b;
      4'h4: e.r = a ^ b;
      4'h5: begin
        u = {32'b0, a} + {32'b0, b} + {63'b0, fi[1]};
        e.r = u[31:0]; c = u[32]; v = ovf(sa + sb + ci);
      end
      4'h6: begin
        e.r = a - b - {31'b0, ~fi[1]};
        c = ({32'b0, a} >= ({32'b0, b} + {63'b0, ~fi[1]}));
        v = ovf(sa - sb - bor);
      end
      4'h7: begin
        e.r = a;
        if (amt != 0) begin
          if (amt < 32)       begin e.r = a << amt; c = a[32 - amt]; end
          else if (amt == 32) begin e.r = '0; c = a[0]; end
          else                begin e.r = '0; c = 1'b0; end
        end
      end
      4'h8: begin
        e.r = a;
        if (amt != 0) begin
          if (amt < 32)       begin e.r = a >> amt; c = a[amt - 1]; end
          else if (amt == 32) begin e.r = '0; c = a[31]; end
          else                begin e.r = '0; c = 1'b0; end
        end
      end
      4'h9: begin
        e.r = a;
        if (amt != 0) begin
          if (amt < 32) begin e.r = 32'($signed(a) >>> amt); c = a[amt - 1]; end
          else          begin e.r = {32{a[31]}}; c = a[31]; end
        end
      end
      4'hA: begin
        e.r = a;
        if (amt != 0) begin
          k = amt % 32;
          e.r = (k == 0) ? a : ((a >> k) | (a << (32 - k)));
          c = e.r[31];
        end
      end
      4'hB: begin u = {32'b0, a} * {32'b0, b}; e.r = u[31:0]; end
      default: begin e.ill = 1'b1; e.r = '0; e.f = fi; return e; end
    endcase
    e.f = {e.r[31], (e.r == 32'd0), c, v};
    return e;
  endfunction

  // Scoreboard: every cycle out of reset, handshake signals and payload are compared with the queue head.
  always @(negedge clk) begin
    ncyc++;
    if (!rst && chk_en) begin
      chk("in_ready", 64'(bus.in_ready), 64'(q.size() == 0));
      chk("out_valid", 64'(bus.out_valid), 64'((q.size() != 0) && (ncyc >= q[0].due)));
      if (bus.out_valid && q.size() != 0) begin
        chk("payload", {27'b0, bus.illegal, bus.flags_out, bus.result},
            {27'b0, q[0].ill, q[0].f, q[0].r});
        if (bus.out_ready) void'(q.pop_front());
      end
    end
  end

  initial begin
    bus.out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      if (mode == 0) bus.out_ready = ($urandom % 4) != 0;
      else           bus.out_ready = (mode == 2);
    end
  end

  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [3:0] f);
    int   n;
    exp_t e;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b1; bus.op = op; bus.op_a = a; bus.op_b = b; bus.flags_in = f;
    n = 0;
    while (!bus.in_ready && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!bus.in_ready) begin
      chk("accept_timeout", 64'(1), 64'(0));
      bus.in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    e = model(op, a, b, f);
    e.due = ncyc + 1 + ((op == 4'hB) ? 32 : 0);
    q.push_back(e);
    #1;
    bus.in_valid = 1'b0;
    bus.op = 4'($urandom); bus.op_a = $urandom; bus.op_b = $urandom; bus.flags_in = 4'($urandom);
  endtask

  task automatic wait_valid(input string name);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.out_valid && n < 100);
    if (!bus.out_valid) chk({name, "_timeout"}, 64'(1), 64'(0));
  endtask

  task automatic directed(input string name, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [3:0] f,
                          input logic [31:0] er, input logic [3:0] ef, input logic eill);
    issue(op, a, b, f);
    wait_valid(name);
    chk({name, "_result"}, 64'(bus.result), 64'(er));
    chk({name, "_nzcv"}, 64'(bus.flags_out), 64'(ef));
    chk({name, "_illegal"}, 64'(bus.illegal), 64'(eill));
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    bus.in_valid = 1'b0;
    q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  function automatic logic [31:0] pick(input int sel);
    logic [31:0] edges [6];
    edges = '{32'h0, 32'h1, 32'h7FFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0001};
    case (sel % 4)
      0:       return edges[$urandom_range(0, 5)];
      1:       return 32'($urandom_range(0, 40)) | ($urandom & 32'hFFFF_FF00);
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int          vcount;
    int          n;
    logic [3:0]  op;
    logic [31:0] a, b;
    bus.in_valid = 1'b0; bus.op = '0; bus.op_a = '0; bus.op_b = '0; bus.flags_in = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", 64'(bus.in_ready), 64'(1));
    chk("rst_out_valid", 64'(bus.out_valid), 64'(0));
    chk("rst_result", 64'(bus.result), 64'(0));
    chk("rst_flags", 64'(bus.flags_out), 64'(0));
    chk("rst_illegal", 64'(bus.illegal), 64'(0));
    chk_en = 1'b1;
    mode = 0;

    directed("add_ovf", 4'h0, 32'h7FFF_FFFF, 32'h1, 4'b0000, 32'h8000_0000, 4'b1001, 1'b0);
    directed("sub_eq",  4'h1, 32'd5, 32'd5, 4'b0000, 32'h0, 4'b0110, 1'b0);
    directed("sbc_00",  4'h6, 32'd0, 32'd0, 4'b0000, 32'hFFFF_FFFF, 4'b1000, 1'b0);
    directed("lsl_1",   4'h7, 32'h8000_0001, 32'd1, 4'b0000, 32'h2, 4'b0010, 1'b0);
    directed("lsl_32",  4'h7, 32'h8000_0001, 32'd32, 4'b0000, 32'h0, 4'b0110, 1'b0);
    directed("lsl_33",  4'h7, 32'h8000_0001, 32'd33, 4'b0000, 32'h0, 4'b0100, 1'b0);
    directed("lsl_0",   4'h7, 32'h8000_0001, 32'd0, 4'b0010, 32'h8000_0001, 4'b1010, 1'b0);
    directed("lsr_32",  4'h8, 32'h8000_0001, 32'd32, 4'b0000, 32'h0, 4'b0110, 1'b0);
    directed("asr_40",  4'h9, 32'h8000_0001, 32'd40, 4'b0001, 32'hFFFF_FFFF, 4'b1011, 1'b0);
    directed("ror_32",  4'hA, 32'h8000_0001, 32'd32, 4'b0000, 32'h8000_0001, 4'b1010, 1'b0);
    directed("mul_ff",  4'hB, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'b0011, 32'h1, 4'b0011, 1'b0);

    // Backpressure: result held with out_ready low, then released.
    issue(4'h0, 32'd3, 32'd4, 4'b0000);
    mode = 1;
    wait_valid("bp");
    for (int i = 0; i < 5; i++) begin
      chk("bp_result", 64'(bus.result), 64'(7));
      chk("bp_flags", 64'(bus.flags_out), 64'(0));
      chk("bp_in_ready", 64'(bus.in_ready), 64'(0));
      @(negedge clk);
    end
    mode = 2;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    chk("bp_release_in_ready", 64'(bus.in_ready), 64'(1));
    chk("bp_release_out_valid", 64'(bus.out_valid), 64'(0));
    mode = 0;

    // Reset in the middle of a MUL drops it.
    issue(4'hB, 32'h1234_5678, 32'h9ABC_DEF0, 4'b0000);
    repeat (8) @(posedge clk);
    do_reset();
    vcount = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.out_valid) vcount++;
    end
    chk("rst_drop_no_valid", 64'(vcount), 64'(0));
    directed("illegal_e", 4'hE, 32'hDEAD_BEEF, 32'h1234_5678, 4'b1010, 32'h0, 4'b1010, 1'b1);

    for (int i = 0; i < 300; i++) begin
      if (($urandom % 8) == 0) op = 4'(12 + ($urandom % 4));
      else                     op = 4'($urandom_range(0, 11));
      a = pick(int'($urandom % 4));
      b = pick(int'($urandom % 4));
      issue(op, a, b, 4'($urandom));
      if (($urandom % 60) == 0) begin
        repeat ($urandom_range(0, 5)) @(posedge clk);
        do_reset();
      end
    end

    mode = 2;
    n = 0;
    while (q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("drain_empty", 64'(q.size()), 64'(0));
    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
